// File: rtl/even_odd_pair_streamer_if.sv
// -----------------------------------------------------------------------------
// even_odd_pair_streamer_if
//   Bus bundle for the even/odd pair streamer.
//   Write side : WrEn, WrAddr ([0]=bank, [PAIR_W:1]=pair), WrData, Go
//   Stream side: Busy, Start, ReadDataEven, ReadDataOdd, PairIdx, Done
//   master modport : the agent that loads words and requests runs
//   slave modport  : the streamer itself
// -----------------------------------------------------------------------------
interface even_odd_pair_streamer_if #(
  parameter int DATA_W = 16,
  parameter int PAIR_W = 2
);
  logic              WrEn;
  logic [PAIR_W:0]   WrAddr;
  logic [DATA_W-1:0] WrData;
  logic              Go;
  logic              Busy;
  logic              Start;
  logic [DATA_W-1:0] ReadDataEven;
  logic [DATA_W-1:0] ReadDataOdd;
  logic [PAIR_W-1:0] PairIdx;
  logic              Done;

  modport master (
    output WrEn, WrAddr, WrData, Go,
    input  Busy, Start, ReadDataEven, ReadDataOdd, PairIdx, Done
  );

  modport slave (
    input  WrEn, WrAddr, WrData, Go,
    output Busy, Start, ReadDataEven, ReadDataOdd, PairIdx, Done
  );
endinterface

// File: rtl/even_odd_pair_streamer.sv
// -----------------------------------------------------------------------------
// even_odd_pair_streamer
//   Dual-bank sample buffer feeding the min/max finder. Words are written into
//   an even bank (address LSB=0) or an odd bank (LSB=1) while idle. A Go request
//   streams one {even, odd} pair per clock with Start high for exactly PAIRS
//   cycles, followed by a one-cycle Done pulse. All outputs are registered.
//
// Ports
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (clears state, outputs and memory)
//   bus   : slave side of even_odd_pair_streamer_if
//           in : WrEn, WrAddr, WrData, Go
//           out: Busy, Start, ReadDataEven, ReadDataOdd, PairIdx, Done
// -----------------------------------------------------------------------------
module even_odd_pair_streamer #(
  parameter int DATA_W = 16,
  parameter int PAIRS  = 4,
  parameter int PAIR_W = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  even_odd_pair_streamer_if.slave   bus
);

  localparam logic [PAIR_W-1:0] LAST_PAIR = PAIR_W'(PAIRS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [PAIR_W-1:0] ptr_q, ptr_d;

  logic [DATA_W-1:0] even_q [PAIRS];
  logic [DATA_W-1:0] odd_q  [PAIRS];

  logic              busy_q, busy_d;
  logic              start_q, start_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] rd_even_q, rd_even_d;
  logic [DATA_W-1:0] rd_odd_q, rd_odd_d;
  logic [PAIR_W-1:0] pair_idx_q, pair_idx_d;
  logic              wr_ok;

  // Next-state and registered-output computation. The output registers are
  // driven from the current state, so Start/Busy trail the state by one edge:
  // the state enters STREAM on the Go edge, pair 0 appears one edge later.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    busy_d     = 1'b0;
    start_d    = 1'b0;
    done_d     = 1'b0;
    rd_even_d  = rd_even_q;
    rd_odd_d   = rd_odd_q;
    pair_idx_d = pair_idx_q;
    wr_ok      = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Writes commit on the same edge as Go, ahead of the pair-0 read.
        wr_ok = bus.WrEn;
        if (bus.Go) begin
          state_d = STREAM;
          ptr_d   = '0;
        end
      end
      STREAM: begin
        busy_d     = 1'b1;
        start_d    = 1'b1;
        rd_even_d  = even_q[ptr_q];
        rd_odd_d   = odd_q[ptr_q];
        pair_idx_d = ptr_q;
        if (ptr_q == LAST_PAIR) begin
          state_d = DONE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        ptr_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q     <= 1'b0;
      start_q    <= 1'b0;
      done_q     <= 1'b0;
      rd_even_q  <= '0;
      rd_odd_q   <= '0;
      pair_idx_q <= '0;
    end else begin
      busy_q     <= busy_d;
      start_q    <= start_d;
      done_q     <= done_d;
      rd_even_q  <= rd_even_d;
      rd_odd_q   <= rd_odd_d;
      pair_idx_q <= pair_idx_d;
    end
  end

  // Sample banks; reset wipes every word so an aborted run leaves no residue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PAIRS; i++) begin
        even_q[i] <= '0;
        odd_q[i]  <= '0;
      end
    end else if (wr_ok) begin
      if (bus.WrAddr[0]) begin
        odd_q[bus.WrAddr[PAIR_W:1]] <= bus.WrData;
      end else begin
        even_q[bus.WrAddr[PAIR_W:1]] <= bus.WrData;
      end
    end
  end

  assign bus.Busy         = busy_q;
  assign bus.Start        = start_q;
  assign bus.Done         = done_q;
  assign bus.ReadDataEven = rd_even_q;
  assign bus.ReadDataOdd  = rd_odd_q;
  assign bus.PairIdx      = pair_idx_q;

endmodule

// File: tb/tb_even_odd_pair_streamer.sv
// -----------------------------------------------------------------------------
// tb_even_odd_pair_streamer
//   Self-checking bench for even_odd_pair_streamer. A timing model tracks the
//   edge at which the last run was accepted; from that, each edge's expected
//   Start/Busy/Done/PairIdx/data follow directly from the run timeline.
// -----------------------------------------------------------------------------
module tb_even_odd_pair_streamer;

  localparam int DW = 16;
  localparam int NP = 4;
  localparam int PW = 2;

  logic clk;
  logic rst_n;

  even_odd_pair_streamer_if #(.DATA_W(DW), .PAIR_W(PW)) bus ();

  even_odd_pair_streamer #(.DATA_W(DW), .PAIRS(NP), .PAIR_W(PW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [DW-1:0] m_even [NP];
  logic [DW-1:0] m_odd  [NP];
  int            cyc   = 0;
  int            run_k = -1000;
  logic          e_start, e_busy, e_done;
  logic [PW-1:0] e_idx;
  logic [DW-1:0] e_even, e_odd;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s at edge %0d: observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".Start"}, 64'(bus.Start), 64'(e_start));
    check({tag, ".Busy"},  64'(bus.Busy),  64'(e_busy));
    check({tag, ".Done"},  64'(bus.Done),  64'(e_done));
    check({tag, ".Idx"},   64'(bus.PairIdx), 64'(e_idx));
    check({tag, ".Even"},  64'(bus.ReadDataEven), 64'(e_even));
    check({tag, ".Odd"},   64'(bus.ReadDataOdd),  64'(e_odd));
  endtask

  task automatic model_reset();
    for (int i = 0; i < NP; i++) begin
      m_even[i] = '0;
      m_odd[i]  = '0;
    end
    run_k   = -1000;
    e_start = 1'b0;
    e_busy  = 1'b0;
    e_done  = 1'b0;
    e_idx   = '0;
    e_even  = '0;
    e_odd   = '0;
  endtask

  // One clock: drive inputs, take the edge, update model, check outputs.
  task automatic step(input string tag, input logic go, input logic wen,
                      input logic [PW:0] waddr, input logic [DW-1:0] wdata);
    int d;
    bus.Go     = go;
    bus.WrEn   = wen;
    bus.WrAddr = waddr;
    bus.WrData = wdata;
    @(posedge clk);
    cyc++;
    // A run accepted at edge k occupies edges k+1 .. k+NP+1; the block is idle
    // (accepting writes and Go) only after that window.
    if (cyc > run_k + NP + 1) begin
      if (wen) begin
        if (waddr[0]) m_odd[waddr[PW:1]] = wdata;
        else          m_even[waddr[PW:1]] = wdata;
      end
      if (go) run_k = cyc;
    end
    #1;
    d = cyc - run_k;
    if (d >= 1 && d <= NP) begin
      e_start = 1'b1;
      e_busy  = 1'b1;
      e_idx   = PW'(d - 1);
      e_even  = m_even[d-1];
      e_odd   = m_odd[d-1];
    end else begin
      e_start = 1'b0;
      e_busy  = 1'b0;
    end
    e_done = (d == NP + 1);
    check_all(tag);
    bus.Go   = 1'b0;
    bus.WrEn = 1'b0;
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic load(input string tag, input logic [DW-1:0] ev [NP], input logic [DW-1:0] od [NP]);
    for (int i = 0; i < NP; i++) begin
      step(tag, 1'b0, 1'b1, {PW'(i), 1'b0}, ev[i]);
      step(tag, 1'b0, 1'b1, {PW'(i), 1'b1}, od[i]);
    end
  endtask

  logic [DW-1:0] ev0 [NP];
  logic [DW-1:0] od0 [NP];
  logic [DW-1:0] rv  [NP];
  logic [DW-1:0] ro  [NP];
  int            start_cnt;

  initial begin
    rst_n      = 1'b1;
    bus.Go     = 1'b0;
    bus.WrEn   = 1'b0;
    bus.WrAddr = '0;
    bus.WrData = '0;
    model_reset();

    // 1: reset asserted before any clock edge -> outputs cleared immediately
    #2 rst_n = 1'b0;
    #1;
    check_all("t1_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // 2: directed load and single-cycle Go
    ev0 = '{16'd3, 16'd9, 16'd1, 16'd7};
    od0 = '{16'd5, 16'd2, 16'd8, 16'd4};
    load("t2_load", ev0, od0);
    step("t2_go", 1'b1, 1'b0, '0, '0);
    step("t2_p0", 1'b0, 1'b0, '0, '0);
    check("t2_p0_even_const", 64'(bus.ReadDataEven), 64'd3);
    check("t2_p0_odd_const",  64'(bus.ReadDataOdd),  64'd5);
    idle("t2_run", NP + 2);

    // 3: Go held for 10 cycles -> exactly two runs
    start_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step("t3_hold", 1'b1, 1'b0, '0, '0);
      if (bus.Start) start_cnt++;
    end
    for (int i = 0; i < 6; i++) begin
      step("t3_tail", 1'b0, 1'b0, '0, '0);
      if (bus.Start) start_cnt++;
    end
    check("t3_start_cycles", 64'(start_cnt), 64'(2 * NP));

    // 4: write during stream is dropped
    step("t4_go", 1'b1, 1'b0, '0, '0);
    step("t4_wr", 1'b0, 1'b1, 3'd0, 16'hFFFF);
    idle("t4_run", NP + 1);
    step("t4_go2", 1'b1, 1'b0, '0, '0);
    step("t4_p0", 1'b0, 1'b0, '0, '0);
    check("t4_p0_even_const", 64'(bus.ReadDataEven), 64'd3);
    idle("t4_run2", NP + 1);

    // 5: write and Go on the same idle edge
    step("t5_go_wr", 1'b1, 1'b1, 3'd1, 16'h0000);
    step("t5_p0", 1'b0, 1'b0, '0, '0);
    check("t5_p0_even_const", 64'(bus.ReadDataEven), 64'd3);
    check("t5_p0_odd_const",  64'(bus.ReadDataOdd),  64'd0);
    idle("t5_run", NP + 1);

    // 6: reset mid-stream at PairIdx=2
    step("t6_go", 1'b1, 1'b0, '0, '0);
    idle("t6_run", 3);
    check("t6_idx_before", 64'(bus.PairIdx), 64'd2);
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("t6_reset");
    @(negedge clk);
    rst_n = 1'b1;
    idle("t6_after", 3);
    step("t6_go2", 1'b1, 1'b0, '0, '0);
    idle("t6_zero_run", NP + 2);

    // Random: reload both banks, then random Go/write traffic
    for (int i = 0; i < NP; i++) begin
      rv[i] = DW'($urandom);
      ro[i] = DW'($urandom);
    end
    load("r_load", rv, ro);
    for (int i = 0; i < 300; i++) begin
      step("r_traffic", ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1),
           (PW + 1)'($urandom), DW'($urandom));
    end
    idle("r_drain", NP + 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
